multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control FSM for the CoreTech processor. Each instruction steps through FETCH, DECODE, EXEC, MEM and WB. The FSM handshakes with the shared instruction/data memory and drives per-cycle strobes to the PC, IR, ALU, register file and memory. It replaces single-cycle decoding for designs whose memory has variable latency. It also keeps a retired-instruction count and a sticky illegal-opcode flag.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high
- opcode  in  8  IR opcode field; stable from DECODE until the instruction ends
- mem_ready  in  1  memory completion for the current mem_req; ignored outside FETCH/MEM
- resume  in  1  leave HALTED
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), 0 = read; meaningful only with mem_req
- ir_write  out  1  latch memory data into IR
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+1, 1 = jump target
- alu_op  out  2  00 AND, 01 OR, 10 ADD/pass, 11 SUB
- alu_src  out  1  1 = immediate operand, 0 = register
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU
- halted  out  1  high in HALTED
- illegal  out  1  sticky; set on an undefined opcode
- retired  out  CNT_W  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- All strobes are combinational from the state and the opcode. Any strobe not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, mem_we=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_write=1 in that cycle, then go to DECODE.
- DECODE (always 1 cycle), by opcode:
  - 0x00, 0x01, 0x09, 0x0A, 0x0B, 0x0C: go to EXEC.
  - 0x02 (load) and 0x03 (store): go to MEM.
  - 0x05 (jmp): pc_write=1, pc_src=1, retire the instruction, go to FETCH.
  - 0xFF (halt): pc_write=1, pc_src=0, retire the instruction, go to HALTED.
  - Any other opcode: treated as a NOP. pc_write=1, pc_src=0, retire the instruction, set illegal, go to FETCH.
- EXEC (always 1 cycle), then go to WB:
  - alu_op: 10 for 0x00/0x01/0x09, 11 for 0x0A, 00 for 0x0B, 01 for 0x0C.
  - alu_src=1 only for 0x00.
- MEM:
  - Outputs: mem_req=1, mem_we=1 for store, mem_we=0 for load. alu_op=10 for the address.
  - Stays in MEM while mem_ready=0.
  - On mem_ready with a load: go to WB.
  - On mem_ready with a store: pc_write=1, pc_src=0, retire the instruction, go to FETCH.
- WB:
  - Outputs: reg_write=1, pc_write=1, pc_src=0. mem_to_reg=1 for load, 0 otherwise.
  - Keeps driving the EXEC alu_op/alu_src so that ALU results are stable during write-back.
  - Retire the instruction, go to FETCH.
- HALTED:
  - Output: halted=1, all strobes 0.
  - resume=1: go to FETCH. PC already points past the halt instruction.
- Retire: retired increments on the clock edge that ends a retiring cycle. It wraps modulo 2^CNT_W.
- illegal: cleared only by reset.

## Timing
- Reset asserted:
  - State goes to FETCH immediately.
  - retired=0, illegal=0.
  - All outputs are forced to 0 while reset is high, including mem_req and halted.
  - The first cycle after reset release is FETCH with mem_req=1.
- Reset mid-instruction (including mid-handshake): the instruction is abandoned and is not retired. Memory must accept the dropped request.
- Latency with mem_ready asserted in the request cycle (zero-wait memory):
  - ALU/mov: 4 cycles.
  - Load: 4 cycles.
  - Store: 3 cycles.
  - jmp: 2 cycles.
  - halt: 2 cycles to reach HALTED.
- Each wait cycle with mem_ready low adds exactly 1 cycle.
- Handshake:
  - mem_req stays high until the cycle in which mem_ready=1.
  - A mem_ready held high across consecutive accesses is valid. Every cycle in FETCH/MEM with mem_ready=1 completes an access.
- resume:
  - Sampled only in HALTED. HALTED lasts at least 1 cycle.
  - resume asserted during the halt's DECODE cycle has no effect.
- retired increments at most once per instruction and never in FETCH, EXEC or HALTED.

## Test plan
- Zero-wait memory, program add, sub, and, or → each takes 4 cycles; alu_op sequence 10, 11, 00, 01; 4 reg_write pulses; retired=4.
- Load with 3 wait cycles in MEM → mem_req high for 4 consecutive MEM cycles; WB has mem_to_reg=1; load total latency 7 cycles.
- Store then jmp → store has mem_we=1 and no reg_write, retired +1; jmp has pc_write with pc_src=1 on its DECODE cycle, 2 cycles total.
- Opcode 0xFF then resume after 5 cycles → halted high for 5 cycles with no strobes; next cycle FETCH with mem_req=1; retired counts the halt once.
- Opcode 0x07 → illegal=1 and stays 1 through later instructions; handled as a NOP with pc_write/pc_src=0; retired increments.
- Reset pulse during MEM wait, plus CNT_W=4 wrap → all outputs 0 during reset, retired=0, FETCH after release; after 16 retires with CNT_W=4, retired=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a memory handshake,
// a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       opcode,
   input  logic             mem_ready,
   input  logic             resume,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALTED = 3'd5
   } state_t;

   localparam logic [7:0] OP_MOVI  = 8'h00;
   localparam logic [7:0] OP_LOAD  = 8'h02;
   localparam logic [7:0] OP_STORE = 8'h03;
   localparam logic [7:0] OP_JMP   = 8'h05;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   state_t           state_r;
   state_t           next_s;
   logic [CNT_W-1:0] retired_r;
   logic             illegal_r;
   logic             retire_s;
   logic             set_ill_s;
   logic             mem_req_s, mem_we_s, ir_write_s, pc_write_s, pc_src_s;
   logic [1:0]       alu_op_s;
   logic             alu_src_s, reg_write_s, mem_to_reg_s, halted_s;

   function automatic logic is_alu(input logic [7:0] op);
      case (op)
         8'h00, 8'h01, 8'h09, 8'h0A, 8'h0B, 8'h0C: is_alu = 1'b1;
         default:                                  is_alu = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] exec_alu(input logic [7:0] op);
      case (op)
         8'h00, 8'h01, 8'h09: exec_alu = 2'b10;
         8'h0A:               exec_alu = 2'b11;
         8'h0B:               exec_alu = 2'b00;
         8'h0C:               exec_alu = 2'b01;
         default:             exec_alu = 2'b00;
      endcase
   endfunction

   // Next-state, strobe and retire decode from the current state and opcode.
   always_comb begin
      next_s       = state_r;
      retire_s     = 1'b0;
      set_ill_s    = 1'b0;
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 1'b0;
      alu_op_s     = 2'b00;
      alu_src_s    = 1'b0;
      reg_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      halted_s     = 1'b0;
      case (state_r)
         FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ready) begin
               ir_write_s = 1'b1;
               next_s     = DECODE;
            end else begin
               next_s = FETCH;
            end
         end
         DECODE: begin
            if (is_alu(opcode)) begin
               next_s = EXEC;
            end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
               next_s = MEM;
            end else if (opcode == OP_JMP) begin
               pc_write_s = 1'b1;
               pc_src_s   = 1'b1;
               retire_s   = 1'b1;
               next_s     = FETCH;
            end else if (opcode == OP_HALT) begin
               pc_write_s = 1'b1;
               retire_s   = 1'b1;
               next_s     = HALTED;
            end else begin
               pc_write_s = 1'b1;
               retire_s   = 1'b1;
               set_ill_s  = 1'b1;
               next_s     = FETCH;
            end
         end
         EXEC: begin
            alu_op_s  = exec_alu(opcode);
            alu_src_s = (opcode == OP_MOVI);
            next_s    = WB;
         end
         MEM: begin
            mem_req_s = 1'b1;
            mem_we_s  = (opcode == OP_STORE);
            alu_op_s  = 2'b10;
            if (!mem_ready) begin
               next_s = MEM;
            end else if (opcode == OP_STORE) begin
               pc_write_s = 1'b1;
               retire_s   = 1'b1;
               next_s     = FETCH;
            end else begin
               next_s = WB;
            end
         end
         WB: begin
            // ALU controls held from EXEC so the write-back value stays stable
            alu_op_s     = exec_alu(opcode);
            alu_src_s    = (opcode == OP_MOVI);
            reg_write_s  = 1'b1;
            pc_write_s   = 1'b1;
            mem_to_reg_s = (opcode == OP_LOAD);
            retire_s     = 1'b1;
            next_s       = FETCH;
         end
         HALTED: begin
            halted_s = 1'b1;
            if (resume) begin
               next_s = FETCH;
            end else begin
               next_s = HALTED;
            end
         end
         default: begin
            next_s = FETCH;
         end
      endcase
   end

   // State, retired counter and sticky illegal flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= FETCH;
         retired_r <= '0;
         illegal_r <= 1'b0;
      end else begin
         state_r <= next_s;
         if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (set_ill_s) begin
            illegal_r <= 1'b1;
         end
      end
   end

   // Strobes are forced low while reset is held, even though the state already reads FETCH.
   assign mem_req    = mem_req_s    & ~reset;
   assign mem_we     = mem_we_s     & ~reset;
   assign ir_write   = ir_write_s   & ~reset;
   assign pc_write   = pc_write_s   & ~reset;
   assign pc_src     = pc_src_s     & ~reset;
   assign alu_op     = alu_op_s     & {2{~reset}};
   assign alu_src    = alu_src_s    & ~reset;
   assign reg_write  = reg_write_s  & ~reset;
   assign mem_to_reg = mem_to_reg_s & ~reset;
   assign halted     = halted_s     & ~reset;
   assign illegal    = illegal_r;
   assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: each issued instruction pushes its expected latency and strobe profile;
// a monitor pops one entry whenever the DUT signals instruction completion with pc_write.
module tb_multicycle_sequencer;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    opcode = 8'h00;
   logic          mem_ready = 1'b0;
   logic          resume = 1'b0;
   logic          mem_req, mem_we, ir_write, pc_write, pc_src;
   logic [1:0]    alu_op;
   logic          alu_src, reg_write, mem_to_reg, halted, illegal;
   logic [CW-1:0] retired;

   multicycle_sequencer #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .resume(resume),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc; int mreq; int mwe; int rw; int pcsrc;
      int chk_alu; int alu; int alus; int m2r; int ret; int ill;
   } exp_t;

   exp_t sq[$];
   int   hq[$];
   int   total = 0;
   int   bad = 0;
   int   ret_m = 0;
   int   ill_m = 0;

   logic [7:0] ops [13] = '{8'h00, 8'h01, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h02,
                            8'h03, 8'h05, 8'hFF, 8'h07, 8'h04, 8'h80};

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int all_outs();
      return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src,
              reg_write, mem_to_reg, halted};
   endfunction

   // Reference model: instruction-level latency and strobe profile from the ISA rules.
   task automatic push_instr(input logic [7:0] op, input int fw, input int mw, input int hl);
      exp_t e;
      e = '{cyc: fw + 2, mreq: fw + 1, mwe: 0, rw: 0, pcsrc: 0,
            chk_alu: 0, alu: 0, alus: 0, m2r: 0, ret: 0, ill: 0};
      case (op)
         8'h00, 8'h01, 8'h09: begin e.cyc = fw + 4; e.rw = 1; e.chk_alu = 1; e.alu = 2; e.alus = (op == 8'h00); end
         8'h0A: begin e.cyc = fw + 4; e.rw = 1; e.chk_alu = 1; e.alu = 3; end
         8'h0B: begin e.cyc = fw + 4; e.rw = 1; e.chk_alu = 1; e.alu = 0; end
         8'h0C: begin e.cyc = fw + 4; e.rw = 1; e.chk_alu = 1; e.alu = 1; end
         8'h02: begin e.cyc = fw + mw + 4; e.mreq = fw + mw + 2; e.rw = 1; e.m2r = 1; end
         8'h03: begin e.cyc = fw + mw + 3; e.mreq = fw + mw + 2; e.mwe = mw + 1; end
         8'h05: e.pcsrc = 1;
         8'hFF: hq.push_back(hl);
         default: ill_m = 1;
      endcase
      ret_m = (ret_m + 1) % (1 << CW);
      e.ret = ret_m;
      e.ill = ill_m;
      sq.push_back(e);
   endtask

   // Entry/exit point: 1 time unit after the rising edge that starts a FETCH (or HALTED) cycle.
   task automatic run_instr(input logic [7:0] op, input int fw, input int mw, input int hl);
      int   wc;
      logic done;
      push_instr(op, fw, mw, hl);
      opcode = op;
      wc = fw;
      done = 1'b0;
      for (int n = 0; n < 64; n++) begin
         if (mem_req) begin
            if (wc > 0) begin
               mem_ready = 1'b0;
               wc--;
            end else begin
               mem_ready = 1'b1;
               wc = mw;
            end
         end else begin
            mem_ready = 1'($urandom_range(1, 0));
         end
         resume = (op == 8'hFF) ? 1'b1 : 1'($urandom_range(1, 0));
         #1;
         done = pc_write;
         @(posedge clk);
         #1;
         if (done) break;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: opcode %0h never completed, expected completion within 64 cycles", op);
      end
      if (op == 8'hFF) begin
         for (int c = 1; c <= hl; c++) begin
            resume = (c == hl);
            mem_ready = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
         end
         resume = 1'b0;
      end
   endtask

   // Monitor: accumulate strobe activity per instruction and score it at each completion.
   int cyc = 0, mreq = 0, mwe = 0, irw = 0, rw = 0, hcnt = 0;
   int a_seen = 0, s_seen = 0, m_seen = 0;
   int retchk = 0, rexp = 0, iexp = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         cyc = 0; mreq = 0; mwe = 0; irw = 0; rw = 0; hcnt = 0; retchk = 0;
      end else begin
         if (retchk != 0) begin
            check("retired", int'(retired), rexp);
            check("illegal", int'(illegal), iexp);
            retchk = 0;
         end
         if (halted) begin
            hcnt++;
            check("halt_quiet", all_outs(), 1);
         end else begin
            if (hcnt > 0) begin
               if (hq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL halt_len: unexpected HALTED span of %0d, expected none", hcnt);
               end else begin
                  check("halt_len", hcnt, hq.pop_front());
               end
               hcnt = 0;
            end
            cyc++;
            mreq += int'(mem_req);
            mwe  += int'(mem_req & mem_we);
            irw  += int'(ir_write);
            rw   += int'(reg_write);
            if (reg_write) begin
               a_seen = int'(alu_op); s_seen = int'(alu_src); m_seen = int'(mem_to_reg);
            end
            if (pc_write) begin
               if (sq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL scoreboard: completion seen, expected queue empty");
               end else begin
                  e = sq.pop_front();
                  check("latency", cyc, e.cyc);
                  check("mem_req_cycles", mreq, e.mreq);
                  check("mem_we_cycles", mwe, e.mwe);
                  check("ir_write_pulses", irw, 1);
                  check("reg_write_pulses", rw, e.rw);
                  check("pc_src", int'(pc_src), e.pcsrc);
                  if (e.rw != 0) check("mem_to_reg", m_seen, e.m2r);
                  if (e.chk_alu != 0) begin
                     check("alu_op", a_seen, e.alu);
                     check("alu_src", s_seen, e.alus);
                  end
                  retchk = 1; rexp = e.ret; iexp = e.ill;
               end
               cyc = 0; mreq = 0; mwe = 0; irw = 0; rw = 0;
            end
         end
      end
   end

   initial begin
      logic [7:0] op;
      #1;
      check("reset_outs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs_held", all_outs(), 0);
      check("reset_retired", int'(retired), 0);
      reset = 1'b0;
      #1;
      check("first_fetch_req", int'(mem_req), 1);
      check("first_illegal", int'(illegal), 0);

      run_instr(8'h09, 0, 0, 0);
      run_instr(8'h0A, 0, 0, 0);
      run_instr(8'h0B, 0, 0, 0);
      run_instr(8'h0C, 0, 0, 0);
      run_instr(8'h02, 0, 3, 0);
      run_instr(8'h03, 0, 0, 0);
      run_instr(8'h05, 0, 0, 0);
      run_instr(8'hFF, 0, 0, 5);
      check("resume_fetch", int'(mem_req), 1);
      run_instr(8'h07, 0, 0, 0);
      run_instr(8'h00, 1, 0, 0);
      run_instr(8'h01, 2, 0, 0);
      run_instr(8'h03, 2, 3, 0);

      for (int i = 0; i < 30; i++) begin
         op = ops[$urandom_range(12, 0)];
         run_instr(op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(4, 1)));
      end

      // Abandon a load in its MEM wait: no retire, counters cleared, back to FETCH.
      opcode = 8'h02;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mem_wait_req", int'(mem_req), 1);
      reset = 1'b1;
      #1;
      check("midreset_outs", all_outs(), 0);
      check("midreset_retired", int'(retired), 0);
      check("midreset_illegal", int'(illegal), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      sq.delete();
      hq.delete();
      ret_m = 0;
      ill_m = 0;
      reset = 1'b0;
      #1;
      check("post_reset_fetch", int'(mem_req), 1);

      for (int i = 0; i < 16; i++) begin
         op = ops[$urandom_range(12, 0)];
         run_instr(op, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                   int'($urandom_range(3, 1)));
      end
      check("retired_wrap", int'(retired), 0);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", sq.size(), 0);
      check("halt_queue_drained", hq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
